// File: rtl/corecomplex_ctrl_pkg.sv
// Shared definitions for the core-complex run controller: geometry of the
// 3x4 node array, FSM state encoding and host command encoding.
package corecomplex_ctrl_pkg;

  localparam int NODES          = 12;
  localparam int WORDS_PER_NODE = 15;
  localparam int PROG_WORDS     = NODES * WORDS_PER_NODE;

  // Range limits in the widths of the ports they are compared against
  localparam logic [7:0] ADDR_LIMIT = 8'(PROG_WORDS);
  localparam logic [3:0] IDX_LIMIT  = 4'(NODES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_HALT    = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_HALT  = 2'd3
  } cmd_e;

endpackage

// File: rtl/corecomplex_ctrl_cfg_regs.sv
// Program image, per-node pLength and stack-flag storage for the core complex.
// Writes land only while the controller allows them (IDLE); any out-of-range
// or disallowed write is dropped and raises the sticky cfg_err flag.
module cc_cfg_regs
  import corecomplex_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        err_clr,
  input  logic                        ld_valid,
  input  logic [7:0]                  ld_addr,
  input  logic [15:0]                 ld_data,
  input  logic                        cfg_we,
  input  logic [3:0]                  cfg_idx,
  input  logic [3:0]                  cfg_len,
  input  logic                        cfg_stack,
  output logic [PROG_WORDS-1:0][15:0] prog,
  output logic [NODES-1:0][3:0]       pLength,
  output logic [NODES-1:0]            stack,
  output logic                        cfg_err
);

  logic ld_ok;
  logic cfg_ok;
  logic wr_bad;

  assign ld_ok  = ld_valid && wr_en && (ld_addr < ADDR_LIMIT);
  assign cfg_ok = cfg_we && wr_en && (cfg_idx < IDX_LIMIT);
  assign wr_bad = (ld_valid && !ld_ok) || (cfg_we && !cfg_ok);

  // Program image: one word written per accepted load request
  // NOTE: this storage is reset because a reset must leave the complex with an
  // all-zero image; the reset fan-out is part of the contract, not an accident.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog <= '0;
    end else if (ld_ok) begin
      prog[ld_addr] <= ld_data;
    end
  end

  // Per-node program length and stack flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pLength <= '0;
      stack   <= '0;
    end else if (cfg_ok) begin
      pLength[cfg_idx] <= cfg_len;
      stack[cfg_idx]   <= cfg_stack;
    end
  end

  // Sticky error: a fresh bad write in the same cycle as a clear still sets it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if (wr_bad) begin
      cfg_err <= 1'b1;
    end else if (err_clr) begin
      cfg_err <= 1'b0;
    end
  end

endmodule

// File: rtl/corecomplex_ctrl.sv
// Run controller for the 3x4 node core complex. Sequences the complex through
// load / run / single-step / halt, counts enabled cycles and bottom-edge
// outputs, and stops once the expected output count is reached.
// Optional feature: define CCCTRL_WATCHDOG_EN to stop a RUN after MAX_CYCLES
// enabled cycles (state TIMEOUT); without it MAX_CYCLES is unused.
module corecomplex_ctrl
  import corecomplex_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [7:0]                  ld_addr,
  input  logic [15:0]                 ld_data,
  input  logic                        cfg_we,
  input  logic [3:0]                  cfg_idx,
  input  logic [3:0]                  cfg_len,
  input  logic                        cfg_stack,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd,
  input  logic [CNT_W-1:0]            exp_out,
  input  logic                        out_fire,
  output logic [PROG_WORDS-1:0][15:0] prog,
  output logic [NODES-1:0][3:0]       pLength,
  output logic [NODES-1:0]            stack,
  output logic                        cc_rst,
  output logic                        cc_ce,
  output logic [2:0]                  state_o,
  output logic [CNT_W-1:0]            cycles,
  output logic [CNT_W-1:0]            out_cnt,
  output logic                        cfg_err
);

  state_e           state_q;
  state_e           state_d;
  cmd_e             cmd_c;
  logic [CNT_W-1:0] exp_q;
  logic             clr;
  logic             latch_exp;
  logic             enabled;
  logic             hit;
  logic             wd_hit;

  assign cmd_c   = cmd_e'(cmd);
  assign enabled = (state_q == ST_RUN) || (state_q == ST_STEP);

  // Completion: the output arriving this cycle is the last one expected
  assign hit = enabled && out_fire && (exp_q != '0) &&
               ((out_cnt + CNT_W'(1)) == exp_q);

`ifdef CCCTRL_WATCHDOG_EN
  // The count reaches MAX_CYCLES at the end of this RUN cycle
  assign wd_hit = (state_q == ST_RUN) && (cycles >= CNT_W'(MAX_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // Moore outputs of the run state
  assign cc_rst   = (state_q == ST_IDLE);
  assign ld_ready = (state_q == ST_IDLE);
  assign cc_ce    = enabled;
  assign state_o  = state_q;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; CLEAR overrides everything, completion beats HALT and watchdog
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    latch_exp = 1'b0;
    if (cmd_valid && cmd_c == CMD_CLEAR) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_c == CMD_RUN) begin
            state_d   = ST_RUN;
            latch_exp = 1'b1;
          end else if (cmd_valid && cmd_c == CMD_STEP) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          if (hit)                                 state_d = ST_DONE;
          else if (wd_hit)                         state_d = ST_TIMEOUT;
          else if (cmd_valid && cmd_c == CMD_HALT) state_d = ST_HALT;
        end
        ST_STEP: begin
          state_d = hit ? ST_DONE : ST_HALT;
        end
        ST_HALT: begin
          if (cmd_valid && cmd_c == CMD_RUN)       state_d = ST_RUN;
          else if (cmd_valid && cmd_c == CMD_STEP) state_d = ST_STEP;
        end
        default: ;
      endcase
    end
  end

  // Saturating cycle and output counters; they only move while the complex is enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      out_cnt <= '0;
    end else if (clr) begin
      cycles  <= '0;
      out_cnt <= '0;
    end else if (enabled) begin
      if (cycles != '1)              cycles  <= cycles + CNT_W'(1);
      if (out_fire && out_cnt != '1) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Expected output count, captured when a run starts from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
    end else if (latch_exp) begin
      exp_q <= exp_out;
    end
  end

  cc_cfg_regs u_cfg_regs (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (state_q == ST_IDLE),
    .err_clr   (clr),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_len   (cfg_len),
    .cfg_stack (cfg_stack),
    .prog      (prog),
    .pLength   (pLength),
    .stack     (stack),
    .cfg_err   (cfg_err)
  );

endmodule

// File: tb/tb_corecomplex_ctrl.sv
// Self-checking bench for corecomplex_ctrl: cycle-by-cycle vector table for the
// run/step/halt/done sequencing, plus hand sequences for loading, write errors,
// counter saturation (or the watchdog when CCCTRL_WATCHDOG_EN is defined) and
// asynchronous reset.
module tb_corecomplex_ctrl;
  import corecomplex_ctrl_pkg::*;

  localparam int CW = 5;
  localparam int MAXC = 20;

  logic                        clk;
  logic                        rst;
  logic                        ld_valid;
  logic                        ld_ready;
  logic [7:0]                  ld_addr;
  logic [15:0]                 ld_data;
  logic                        cfg_we;
  logic [3:0]                  cfg_idx;
  logic [3:0]                  cfg_len;
  logic                        cfg_stack;
  logic                        cmd_valid;
  logic [1:0]                  cmd;
  logic [CW-1:0]               exp_out;
  logic                        out_fire;
  logic [PROG_WORDS-1:0][15:0] prog;
  logic [NODES-1:0][3:0]       pLength;
  logic [NODES-1:0]            stack;
  logic                        cc_rst;
  logic                        cc_ce;
  logic [2:0]                  state_o;
  logic [CW-1:0]               cycles;
  logic [CW-1:0]               out_cnt;
  logic                        cfg_err;

  corecomplex_ctrl #(.CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_len(cfg_len), .cfg_stack(cfg_stack),
    .cmd_valid(cmd_valid), .cmd(cmd), .exp_out(exp_out), .out_fire(out_fire),
    .prog(prog), .pLength(pLength), .stack(stack),
    .cc_rst(cc_rst), .cc_ce(cc_ce), .state_o(state_o),
    .cycles(cycles), .out_cnt(out_cnt), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic    cv;
    cmd_e    c;
    logic    f;
    logic [CW-1:0] e;
    state_e  st;
    logic [CW-1:0] cy;
    logic [CW-1:0] oc;
  } vec_t;

  vec_t tbl [34];
  int   checks = 0;
  int   errors = 0;
  int   bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input cmd_e c, input logic f, input logic [CW-1:0] e);
    cmd_valid = cv;
    cmd       = c;
    out_fire  = f;
    exp_out   = e;
    ld_valid  = 1'b0;
    cfg_we    = 1'b0;
  endtask

  function automatic vec_t v(input logic cv, input cmd_e c, input logic f, input int e,
                             input state_e st, input int cy, input int oc);
    vec_t r;
    r.cv = cv; r.c = c; r.f = f; r.e = CW'(e);
    r.st = st; r.cy = CW'(cy); r.oc = CW'(oc);
    return r;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].cv, tbl[i].c, tbl[i].f, tbl[i].e);
      tick();
      check($sformatf("row%0d state", i), 32'(state_o), 32'(tbl[i].st));
      check($sformatf("row%0d cc_rst", i), 32'(cc_rst), 32'(tbl[i].st == ST_IDLE));
      check($sformatf("row%0d cc_ce", i), 32'(cc_ce),
            32'(tbl[i].st == ST_RUN || tbl[i].st == ST_STEP));
      check($sformatf("row%0d cycles", i), 32'(cycles), 32'(tbl[i].cy));
      check($sformatf("row%0d out_cnt", i), 32'(out_cnt), 32'(tbl[i].oc));
    end
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
  endtask

  task automatic count_prog_bad(input bit expect_zero, output int n);
    n = 0;
    for (int i = 0; i < PROG_WORDS; i++) begin
      if (prog[i] !== (expect_zero ? 16'h0 : 16'(i))) n++;
    end
  endtask

  task automatic count_cfg_bad(output int n);
    n = 0;
    for (int k = 0; k < NODES; k++) begin
      if (pLength[k] !== 4'(k + 1) || stack[k] !== k[0]) n++;
    end
  endtask

  initial begin
    // Scenario 2 / 4: RUN with exp_out=3, outputs at t+5, t+9, t+12
    tbl[0]  = v(1, CMD_RUN,   0, 3, ST_RUN,  0, 0);
    tbl[1]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  1, 0);
    tbl[2]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  2, 0);
    tbl[3]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  3, 0);
    tbl[4]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  4, 0);
    tbl[5]  = v(0, CMD_CLEAR, 1, 7, ST_RUN,  5, 1);
    tbl[6]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  6, 1);
    tbl[7]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  7, 1);
    tbl[8]  = v(0, CMD_CLEAR, 0, 7, ST_RUN,  8, 1);
    tbl[9]  = v(0, CMD_CLEAR, 1, 7, ST_RUN,  9, 2);
    tbl[10] = v(0, CMD_CLEAR, 0, 7, ST_RUN, 10, 2);
    tbl[11] = v(0, CMD_CLEAR, 0, 7, ST_RUN, 11, 2);
    tbl[12] = v(0, CMD_CLEAR, 1, 7, ST_DONE, 12, 3);
    tbl[13] = v(0, CMD_CLEAR, 0, 7, ST_DONE, 12, 3);
    tbl[14] = v(1, CMD_HALT,  1, 7, ST_DONE, 12, 3);
    tbl[15] = v(1, CMD_RUN,   0, 7, ST_DONE, 12, 3);
    tbl[16] = v(1, CMD_CLEAR, 0, 7, ST_IDLE,  0, 0);
    // Scenario 3: RUN, HALT, single steps, ignored commands
    tbl[17] = v(1, CMD_RUN,   0, 0, ST_RUN,  0, 0);
    tbl[18] = v(0, CMD_CLEAR, 0, 7, ST_RUN,  1, 0);
    tbl[19] = v(1, CMD_HALT,  0, 7, ST_HALT, 2, 0);
    tbl[20] = v(0, CMD_CLEAR, 1, 7, ST_HALT, 2, 0);
    tbl[21] = v(1, CMD_STEP,  0, 7, ST_STEP, 2, 0);
    tbl[22] = v(1, CMD_RUN,   1, 7, ST_HALT, 3, 1);
    tbl[23] = v(1, CMD_STEP,  0, 7, ST_STEP, 3, 1);
    tbl[24] = v(0, CMD_CLEAR, 0, 7, ST_HALT, 4, 1);
    tbl[25] = v(1, CMD_RUN,   0, 7, ST_RUN,  4, 1);
    tbl[26] = v(1, CMD_STEP,  0, 7, ST_RUN,  5, 1);
    tbl[27] = v(1, CMD_CLEAR, 0, 7, ST_IDLE, 0, 0);
    tbl[28] = v(1, CMD_HALT,  0, 7, ST_IDLE, 0, 0);
    tbl[29] = v(1, CMD_STEP,  0, 7, ST_STEP, 0, 0);
    tbl[30] = v(1, CMD_CLEAR, 0, 7, ST_IDLE, 0, 0);
    // Completion beats a simultaneous HALT
    tbl[31] = v(1, CMD_RUN,   0, 1, ST_RUN,  0, 0);
    tbl[32] = v(1, CMD_HALT,  1, 7, ST_DONE, 1, 1);
    tbl[33] = v(1, CMD_CLEAR, 0, 7, ST_IDLE, 0, 0);

    rst = 1'b1;
    ld_addr = '0; ld_data = '0; cfg_idx = '0; cfg_len = '0; cfg_stack = 1'b0;
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset state", 32'(state_o), 32'(ST_IDLE));
    check("reset cc_rst", 32'(cc_rst), 32'd1);
    check("reset cc_ce", 32'(cc_ce), 32'd0);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset cycles", 32'(cycles), 32'd0);
    check("reset out_cnt", 32'(out_cnt), 32'd0);
    check("reset cfg_err", 32'(cfg_err), 32'd0);
    count_prog_bad(1'b1, bad);
    check("reset prog zero", 32'(bad), 32'd0);

    // Scenario 1: load the image and node configuration
    for (int a = 0; a < PROG_WORDS; a++) begin
      ld_valid = 1'b1; ld_addr = 8'(a); ld_data = 16'(a);
      tick();
    end
    ld_valid = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      cfg_we = 1'b1; cfg_idx = 4'(n); cfg_len = 4'(n + 1); cfg_stack = n[0];
      tick();
    end
    cfg_we = 1'b0;
    check("load cfg_err clean", 32'(cfg_err), 32'd0);
    count_prog_bad(1'b0, bad);
    check("prog image", 32'(bad), 32'd0);
    count_cfg_bad(bad);
    check("node cfg", 32'(bad), 32'd0);

    ld_valid = 1'b1; ld_addr = 8'd200; ld_data = 16'hFFFF;
    tick();
    ld_valid = 1'b0;
    check("ld 200 cfg_err", 32'(cfg_err), 32'd1);
    count_prog_bad(1'b0, bad);
    check("ld 200 dropped", 32'(bad), 32'd0);

    drive(1'b1, CMD_CLEAR, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    check("clear cfg_err", 32'(cfg_err), 32'd0);

    cfg_we = 1'b1; cfg_idx = 4'd12; cfg_len = 4'hF; cfg_stack = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("idx 12 cfg_err", 32'(cfg_err), 32'd1);
    count_cfg_bad(bad);
    check("idx 12 dropped", 32'(bad), 32'd0);
    drive(1'b1, CMD_CLEAR, 1'b0, '0);
    tick();

    // Scenario 2, then CLEAR and replay (scenario 4)
    run_rows(0, 16);
    check("after clear cfg_err", 32'(cfg_err), 32'd0);
    count_prog_bad(1'b0, bad);
    check("prog kept over clear", 32'(bad), 32'd0);
    run_rows(0, 16);
    run_rows(17, 33);

    // Writes while running are dropped and flagged
    drive(1'b1, CMD_RUN, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    check("run ld_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 16'hBEEF;
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_len = 4'hF; cfg_stack = 1'b1;
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    check("run write cfg_err", 32'(cfg_err), 32'd1);
    check("run write prog5", 32'(prog[5]), 32'd5);
    check("run write plen0", 32'(pLength[0]), 32'd1);
    drive(1'b1, CMD_CLEAR, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);

`ifdef CCCTRL_WATCHDOG_EN
    // Scenario 5, watchdog on: TIMEOUT after MAXC enabled cycles
    drive(1'b1, CMD_RUN, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    for (int k = 1; k <= MAXC; k++) begin
      tick();
      if (k == MAXC - 1) check("wd before limit", 32'(state_o), 32'(ST_RUN));
    end
    check("wd timeout state", 32'(state_o), 32'(ST_TIMEOUT));
    check("wd timeout cycles", 32'(cycles), 32'(MAXC));
    check("wd timeout cc_ce", 32'(cc_ce), 32'd0);
    drive(1'b1, CMD_RUN, 1'b1, '0);
    tick();
    check("wd timeout sticky", 32'(state_o), 32'(ST_TIMEOUT));
    check("wd frozen out_cnt", 32'(out_cnt), 32'd0);
`else
    // Scenario 5, watchdog off: RUN continues; counters saturate at all-ones
    drive(1'b1, CMD_RUN, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b1, '0);
    for (int k = 1; k <= 2 * MAXC; k++) begin
      tick();
      if (k == MAXC) begin
        check("no wd state", 32'(state_o), 32'(ST_RUN));
        check("no wd cycles", 32'(cycles), 32'(MAXC));
      end
    end
    check("sat state", 32'(state_o), 32'(ST_RUN));
    check("sat cycles", 32'(cycles), 32'(2 ** CW - 1));
    check("sat out_cnt", 32'(out_cnt), 32'(2 ** CW - 1));
`endif
    drive(1'b1, CMD_CLEAR, 1'b0, '0);
    tick();
    check("clear after run", 32'(state_o), 32'(ST_IDLE));

    // Scenario 6: asynchronous reset during RUN
    drive(1'b1, CMD_RUN, 1'b0, '0);
    tick();
    drive(1'b0, CMD_CLEAR, 1'b0, '0);
    tick();
    tick();
    check("pre-rst state", 32'(state_o), 32'(ST_RUN));
    #2 rst = 1'b1;
    #1;
    check("rst state", 32'(state_o), 32'(ST_IDLE));
    check("rst cc_rst", 32'(cc_rst), 32'd1);
    check("rst cc_ce", 32'(cc_ce), 32'd0);
    check("rst cycles", 32'(cycles), 32'd0);
    count_prog_bad(1'b1, bad);
    check("rst prog zero", 32'(bad), 32'd0);
    check("rst pLength zero", 32'(pLength), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post-rst state", 32'(state_o), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
